road_jam_detector: RTL
======================

Name: road_jam_detector

Overview:
- Roadside front end for the intersection controller. It produces the four jam_sensor_N inputs and consumes the four allow_N grants.
- It keeps a per-road queue occupancy count from vehicle arrival and departure pulses.
- It asserts jam_sensor_N with hysteresis and debounce so the controller never sees a chattering jam indication.
- Four identical lane monitors share one clock and reset. Outputs are registered.

Parameters:
- CNT_W, 6, queue counter width; count saturates at 2^CNT_W-1.
- JAM_ON, 20, occupancy at or above which a jam is pending.
- JAM_OFF, 8, occupancy at or below which a jam clear is pending. Must satisfy JAM_OFF < JAM_ON <= 2^CNT_W-1.
- DEBOUNCE, 4, consecutive cycles a condition must hold before jam_sensor changes. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arrive  in  4  bit N: one-cycle pulse, vehicle joined road N queue
- depart  in  4  bit N: one-cycle pulse, vehicle left road N stop line
- allow_0..allow_3  in  1 each  grant from controller; a road may discharge only while its allow is high
- err_clr  in  1  synchronous clear of all sticky error bits
- jam_sensor_0..jam_sensor_3  out  1 each  registered jam indication to controller
- queue_cnt  out  4*CNT_W  packed occupancy; road N at [N*CNT_W +: CNT_W]
- err_underflow  out  4  sticky: depart on road N while its count is 0
- err_violation  out  4  sticky: depart on road N while allow_N is low
- err_overflow  out  4  sticky: arrive on road N while its count is saturated

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream) drives the following for every road:
  - count = 0
  - state = CLEAR
  - debounce counter = 0
  - jam_sensor_N = 0
  - all error bits = 0
- Counter update is registered, so queue_cnt reflects a pulse one cycle later. The net delta per road per cycle is:
  - arrive only: +1
  - depart only with allow high: -1
  - arrive and depart together with allow high: 0, no error
  - depart with allow low: ignored, sets err_violation[N]; a simultaneous arrive still counts +1
  - depart with count 0 (allow high): ignored, sets err_underflow[N]
  - arrive at 2^CNT_W-1 (no valid depart): held, sets err_overflow[N]
  - if arrive and depart coincide at the saturated or zero boundary with allow high, the net is 0 and no error is raised
- Error bits are sticky until err_clr. When err_clr and a new error event occur in the same cycle, the set wins.
- Per-road FSM evaluates the registered count. db is the debounce counter.
  - CLEAR: if count >= JAM_ON, go to PEND_ON with db = 1.
  - PEND_ON:
    - if count < JAM_ON, go to CLEAR with db = 0;
    - else if db == DEBOUNCE, go to JAMMED;
    - else db++.
  - JAMMED: if count <= JAM_OFF, go to PEND_OFF with db = 1.
  - PEND_OFF:
    - if count > JAM_OFF, go to JAMMED with db = 0;
    - else if db == DEBOUNCE, go to CLEAR;
    - else db++.
- jam_sensor_N is registered and equals 1 in JAMMED or PEND_OFF.
- Latency: once count first reaches JAM_ON at edge k and stays there, jam_sensor rises at edge k+DEBOUNCE+1. The clear direction is symmetric.
- Counts between JAM_OFF and JAM_ON never change jam_sensor (hysteresis band).
- Asserting reset mid-debounce or mid-jam returns the road to CLEAR immediately and drops jam_sensor asynchronously.
- Roads are fully independent; there are no cross-road interactions.

Decomposition:
- Shared package road_pkg holds:
  - the lane state enum {CLEAR, PEND_ON, JAMMED, PEND_OFF} (2 bits);
  - NUM_ROADS = 4;
  - the default CNT_W, JAM_ON, JAM_OFF and DEBOUNCE values, also used by the controller bench.
- Sub-module lane_jam_monitor holds one road's counter, FSM, debounce counter and three error bits. It is instantiated four times.
- The top level handles only port fan-out, queue_cnt packing and err_clr distribution.

Test Plan:
- Fill: 20 arrive pulses on road 0 with allow_0 low.
  - queue_cnt[0] = 20.
  - jam_sensor_0 rises exactly 5 cycles after the count reaches 20.
  - Other roads stay 0.
- Hysteresis: from count 20 jammed, raise allow_0 and send 11 departs (count 9).
  - jam_sensor_0 stays 1.
  - One more depart (count 8) makes jam_sensor_0 fall 5 cycles later.
- Debounce glitch: on road 1, count at 19. Send arrive, then a depart 2 cycles later with allow_1 high (count 20 for 2 cycles, then 19).
  - FSM returns to CLEAR.
  - jam_sensor_1 never asserts.
- Simultaneous events: road 2 at count 5 with allow_2 high; arrive and depart in the same cycle.
  - Count stays 5, no errors.
  - Repeat with allow_2 low: count becomes 6 and err_violation[2] = 1.
- Boundaries on road 3:
  - depart at count 0 (allow high): err_underflow[3] = 1, count stays 0.
  - 64 arrivals: count saturates at 63 and err_overflow[3] = 1.
  - err_clr clears both bits the next cycle.
- Reset mid-operation: assert rst while road 0 is JAMMED and road 1 is PEND_ON.
  - All jam_sensors drop to 0 without waiting for a clock edge.
  - All counts and error bits read 0 after release.

Source files
------------

// File: rtl/road_pkg.sv
// Shared definitions for the roadside jam detector: lane states and default
// thresholds, also used by the controller bench.
package road_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    PEND_ON  = 2'd1,
    JAMMED   = 2'd2,
    PEND_OFF = 2'd3
  } lane_state_e;

  localparam int NUM_ROADS    = 4;
  localparam int DEF_CNT_W    = 6;
  localparam int DEF_JAM_ON   = 20;
  localparam int DEF_JAM_OFF  = 8;
  localparam int DEF_DEBOUNCE = 4;

endpackage

// File: rtl/lane_jam_monitor.sv
// One road: saturating queue occupancy counter, debounced jam FSM with
// hysteresis, and three sticky error flags.
module lane_jam_monitor
  import road_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int JAM_ON   = DEF_JAM_ON,
  parameter int JAM_OFF  = DEF_JAM_OFF,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive,
  input  logic             depart,
  input  logic             allow,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             jam,
  output logic             err_underflow,
  output logic             err_violation,
  output logic             err_overflow,
  output lane_state_e      state
);

  localparam int              DB_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ON_TH   = CNT_W'(JAM_ON);
  localparam logic [CNT_W-1:0] OFF_TH  = CNT_W'(JAM_OFF);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DB_W-1:0]  db_q, db_d;
  lane_state_e      state_q, state_d;
  logic             jam_q, jam_d;
  logic             un_q, un_d, vi_q, vi_d, ov_q, ov_d;
  logic             dep_ok, un_ev, vi_ev, ov_ev;

  // A depart without allow never moves the count; an arrive in the same
  // cycle still counts on its own.
  always_comb begin
    cnt_d  = cnt_q;
    un_ev  = 1'b0;
    ov_ev  = 1'b0;
    dep_ok = depart & allow;
    vi_ev  = depart & ~allow;
    if (arrive && dep_ok) begin
      cnt_d = cnt_q;
    end else if (arrive) begin
      if (cnt_q == CNT_MAX) ov_ev = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else if (dep_ok) begin
      if (cnt_q == '0) un_ev = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
    un_d = (un_q & ~err_clr) | un_ev;
    vi_d = (vi_q & ~err_clr) | vi_ev;
    ov_d = (ov_q & ~err_clr) | ov_ev;
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q >= ON_TH) begin
          state_d = PEND_ON;
          db_d    = DB_W'(1);
        end
      end
      PEND_ON: begin
        if (cnt_q < ON_TH) begin
          state_d = CLEAR;
          db_d    = '0;
        end else if (db_q == DB_MAX) begin
          state_d = JAMMED;
          db_d    = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      JAMMED: begin
        if (cnt_q <= OFF_TH) begin
          state_d = PEND_OFF;
          db_d    = DB_W'(1);
        end
      end
      PEND_OFF: begin
        if (cnt_q > OFF_TH) begin
          state_d = JAMMED;
          db_d    = '0;
        end else if (db_q == DB_MAX) begin
          state_d = CLEAR;
          db_d    = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        db_d    = '0;
      end
    endcase
    jam_d = (state_d == JAMMED) || (state_d == PEND_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      db_q    <= '0;
      state_q <= CLEAR;
      jam_q   <= 1'b0;
      un_q    <= 1'b0;
      vi_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      state_q <= state_d;
      jam_q   <= jam_d;
      un_q    <= un_d;
      vi_q    <= vi_d;
      ov_q    <= ov_d;
    end
  end

  assign cnt           = cnt_q;
  assign jam           = jam_q;
  assign err_underflow = un_q;
  assign err_violation = vi_q;
  assign err_overflow  = ov_q;
  assign state         = state_q;

endmodule

// File: rtl/road_jam_detector.sv
// Roadside front end: four independent lane monitors feeding the intersection
// controller's jam sensors; lane FSM states are exported on dbg_lane_state.
module road_jam_detector
  import road_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int JAM_ON   = DEF_JAM_ON,
  parameter int JAM_OFF  = DEF_JAM_OFF,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ROADS-1:0]       arrive,
  input  logic [NUM_ROADS-1:0]       depart,
  input  logic                       allow_0,
  input  logic                       allow_1,
  input  logic                       allow_2,
  input  logic                       allow_3,
  input  logic                       err_clr,
  output logic                       jam_sensor_0,
  output logic                       jam_sensor_1,
  output logic                       jam_sensor_2,
  output logic                       jam_sensor_3,
  output logic [NUM_ROADS*CNT_W-1:0] queue_cnt,
  output logic [NUM_ROADS-1:0]       err_underflow,
  output logic [NUM_ROADS-1:0]       err_violation,
  output logic [NUM_ROADS-1:0]       err_overflow,
  output logic [2*NUM_ROADS-1:0]     dbg_lane_state
);

  logic [NUM_ROADS-1:0] allow_v;
  logic [NUM_ROADS-1:0] jam_v;

  assign allow_v = {allow_3, allow_2, allow_1, allow_0};

  for (genvar g = 0; g < NUM_ROADS; g++) begin : g_lane
    lane_state_e lane_state;

    lane_jam_monitor #(
      .CNT_W    (CNT_W),
      .JAM_ON   (JAM_ON),
      .JAM_OFF  (JAM_OFF),
      .DEBOUNCE (DEBOUNCE)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .arrive        (arrive[g]),
      .depart        (depart[g]),
      .allow         (allow_v[g]),
      .err_clr       (err_clr),
      .cnt           (queue_cnt[g*CNT_W +: CNT_W]),
      .jam           (jam_v[g]),
      .err_underflow (err_underflow[g]),
      .err_violation (err_violation[g]),
      .err_overflow  (err_overflow[g]),
      .state         (lane_state)
    );

    assign dbg_lane_state[2*g +: 2] = lane_state;
  end

  assign jam_sensor_0 = jam_v[0];
  assign jam_sensor_1 = jam_v[1];
  assign jam_sensor_2 = jam_v[2];
  assign jam_sensor_3 = jam_v[3];

endmodule
